// File: rtl/lsu_word_adapter_if.sv
// Request/response/memory bundle for lsu_word_adapter.
// Optional trace outputs are present when LSU_RVFI_EN is defined.
interface lsu_word_adapter_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_value;
   logic [2:0]  mem_funct3;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_data;
`ifdef LSU_RVFI_EN
   logic [3:0]  rvfi_rmask;
   logic [3:0]  rvfi_wmask;
   logic [31:0] rvfi_addr;

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data,
      output req_ready, resp_valid, resp_rdata, resp_fault,
             mem_addr, mem_value, mem_funct3, mem_read, mem_write,
             rvfi_rmask, rvfi_wmask, rvfi_addr
   );
   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
             mem_addr, mem_value, mem_funct3, mem_read, mem_write,
             rvfi_rmask, rvfi_wmask, rvfi_addr
   );
`else
   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data,
      output req_ready, resp_valid, resp_rdata, resp_fault,
             mem_addr, mem_value, mem_funct3, mem_read, mem_write
   );
   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
             mem_addr, mem_value, mem_funct3, mem_read, mem_write
   );
`endif
endinterface

// File: rtl/lsu_word_adapter.sv
// Byte-addressed load/store to full-word memory adapter (read, merge, write).
// Define LSU_RVFI_EN to add rvfi_rmask/rvfi_wmask/rvfi_addr trace outputs.
module lsu_word_adapter #(
   parameter int unsigned MEMSIZE = 64
) (
   input logic              clk,
   input logic              rst_n,
   lsu_word_adapter_if.slave bus
);
   typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

   state_t      state, state_nx;
   logic [31:0] addr_q, wdata_q, rdata_q, merged_q;
   logic [2:0]  funct3_q;
   logic        write_q, fault_q;
   logic        accept, fault_chk;
   logic [31:0] word_idx, shifted, load_val, store_val, lane_data;
   logic [3:0]  lane_mask;

   assign accept         = bus.req_valid && (state == IDLE);
   assign word_idx       = {2'b00, addr_q[31:2]};
   assign bus.mem_funct3 = 3'd2;

   always_comb begin
      fault_chk = 1'b0;
      if (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) fault_chk = 1'b1;
      if (bus.req_funct3 == 3'd2 && bus.req_addr[1:0] != 2'd0) fault_chk = 1'b1;
      if (!bus.req_write && (bus.req_funct3 == 3'd3 || bus.req_funct3 == 3'd6 ||
                             bus.req_funct3 == 3'd7)) fault_chk = 1'b1;
      if (bus.req_write && bus.req_funct3 > 3'd2) fault_chk = 1'b1;
      if ({2'b00, bus.req_addr[31:2]} >= MEMSIZE) fault_chk = 1'b1;
   end

   // Load lane extraction: shift the addressed lane down to bit 0, then extend.
   always_comb begin
      shifted  = bus.mem_data >> {addr_q[1:0], 3'b000};
      load_val = '0;
      case (funct3_q)
         3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'd2:    load_val = bus.mem_data;
         3'd4:    load_val = {24'd0, shifted[7:0]};
         3'd5:    load_val = {16'd0, shifted[15:0]};
         default: load_val = '0;
      endcase
   end

   always_comb begin
      lane_mask = 4'b1111;
      lane_data = wdata_q;
      case (funct3_q[1:0])
         2'd0: begin
            lane_mask = 4'b0001 << addr_q[1:0];
            lane_data = {4{wdata_q[7:0]}};
         end
         2'd1: begin
            lane_mask = 4'b0011 << addr_q[1:0];
            lane_data = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
      store_val = bus.mem_data;
      for (int unsigned i = 0; i < 4; i++)
         if (lane_mask[i]) store_val[8*i +: 8] = lane_data[8*i +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx       = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_fault = 1'b0;
      bus.resp_rdata = '0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_value  = '0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_nx = fault_chk ? RESP : READ;
         end
         READ: begin
            bus.mem_read = 1'b1;
            bus.mem_addr = word_idx;
            state_nx     = MERGE;
         end
         MERGE: state_nx = write_q ? WRITE : RESP;
         WRITE: begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = word_idx;
            bus.mem_value = merged_q;
            state_nx      = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_fault = fault_q;
            bus.resp_rdata = rdata_q;
            state_nx       = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         write_q  <= 1'b0;
         fault_q  <= 1'b0;
         rdata_q  <= '0;
         merged_q <= '0;
      end else begin
         if (accept) begin
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            funct3_q <= bus.req_funct3;
            write_q  <= bus.req_write;
            fault_q  <= fault_chk;
            rdata_q  <= '0;
         end
         if (state == MERGE) begin
            if (write_q) merged_q <= store_val;
            else         rdata_q  <= load_val;
         end
      end
   end

`ifdef LSU_RVFI_EN
   logic [3:0]  req_mask, rmask_q, wmask_q;
   logic [31:0] raddr_q;

   always_comb begin
      case (bus.req_funct3[1:0])
         2'd0:    req_mask = 4'b0001 << bus.req_addr[1:0];
         2'd1:    req_mask = 4'b0011 << bus.req_addr[1:0];
         2'd2:    req_mask = 4'b1111;
         default: req_mask = 4'b0000;
      endcase
   end

   // Store RMW reads are internal, so stores report only a write mask.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rmask_q <= '0;
         wmask_q <= '0;
         raddr_q <= '0;
      end else if (accept) begin
         rmask_q <= (fault_chk || bus.req_write)  ? 4'b0000 : req_mask;
         wmask_q <= (fault_chk || !bus.req_write) ? 4'b0000 : req_mask;
         raddr_q <= bus.req_addr;
      end
   end

   assign bus.rvfi_rmask = (state == RESP) ? rmask_q : '0;
   assign bus.rvfi_wmask = (state == RESP) ? wmask_q : '0;
   assign bus.rvfi_addr  = (state == RESP) ? raddr_q : '0;
`endif
endmodule
